// File: rtl/demux_out32.sv
// Registered 1-to-2 demux: 1-cycle latency, per-channel 1-entry output register; full throughput.
// Backpressure per channel (sel 0/1 stall only on their own channel); sel 2/3 words are always accepted and dropped.
module demux_out32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             drop_err,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } chan_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  chan_t ch0_q;
  chan_t ch1_q;

  logic can0;
  logic can1;
  logic xfer;
  logic fill0;
  logic fill1;
  logic drop;

  // A channel can take a word when empty or when its held word leaves this cycle.
  assign can0 = !ch0_q.valid || out0_ready;
  assign can1 = !ch1_q.valid || out1_ready;

  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      2'd0:    in_ready = can0;
      2'd1:    in_ready = can1;
      default: in_ready = 1'b1;
    endcase
  end

  assign xfer  = in_valid && in_ready;
  assign fill0 = xfer && (in_sel == 2'd0);
  assign fill1 = xfer && (in_sel == 2'd1);
  assign drop  = xfer && in_sel[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch0_q <= '0;
    end else if (fill0) begin
      ch0_q.valid <= 1'b1;
      ch0_q.data  <= in_data;
    end else if (out0_ready) begin
      ch0_q.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch1_q <= '0;
    end else if (fill1) begin
      ch1_q.valid <= 1'b1;
      ch1_q.data  <= in_data;
    end else if (out1_ready) begin
      ch1_q.valid <= 1'b0;
    end
  end

  // Drop counter saturates at all-ones; drop_err echoes each drop for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drop_err <= drop;
      if (drop && (drop_cnt != CNT_MAX)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  assign out0_valid = ch0_q.valid;
  assign out0_data  = ch0_q.data;
  assign out1_valid = ch1_q.valid;
  assign out1_data  = ch1_q.data;

endmodule

// File: doc/demux_out32.md
Name: demux_out32

Overview:
- Registered 1-to-2 demultiplexer: the inverse of the 32-bit 2:1 select mux.
- Routes one 32-bit source word, tagged with a 2-bit select, to one of two destination channels. Valid/ready handshakes on every side.
- Sits between datapath producers and two consumers (e.g. data memory write port vs. MMIO write port).
- Select codes 2 and 3 are undefined destinations: those words are consumed, dropped and counted.

Parameters:
- WIDTH, 32, data width of input and both output channels
- CNT_W, 8, width of the saturating drop counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  source word present
- in_ready  output  1  block accepts source word this cycle
- in_sel  input  2  destination: 0 -> ch0, 1 -> ch1, 2/3 -> invalid
- in_data  input  WIDTH  source word
- out0_valid  output  1  ch0 holds a word
- out0_ready  input  1  ch0 consumer accepts
- out0_data  output  WIDTH  ch0 word
- out1_valid  output  1  ch1 holds a word
- out1_ready  input  1  ch1 consumer accepts
- out1_data  output  WIDTH  ch1 word
- drop_err  output  1  one-cycle pulse: a word with sel 2/3 was dropped
- drop_cnt  output  CNT_W  count of dropped words, saturating

Behaviour:
- Reset (rst_n low, asynchronous; released synchronously to clk by the system):
  - out0_valid = out1_valid = 0, out0_data = out1_data = 0, drop_err = 0, drop_cnt = 0.
  - Any buffered word is discarded, including mid-transfer.
- Each channel has a 1-entry output register (valid bit + data).
- Channel k "can_accept" = !outk_valid | outk_ready.
- in_ready is combinational:
  - sel = 0: can_accept(ch0)
  - sel = 1: can_accept(ch1)
  - sel = 2/3: 1 (always accepted)
- in_ready does not depend on in_valid.
- Transfer occurs when in_valid & in_ready at a rising edge.
- Transfer with sel = k (k = 0/1):
  - outk_data <= in_data, outk_valid <= 1 on that edge.
  - Latency 1 cycle: the word is visible on outk the cycle after acceptance.
- Drain: when outk_valid & outk_ready and no new transfer to k on that edge, outk_valid <= 0. outk_data holds its last value.
- Simultaneous drain and fill of the same channel: new word replaces the old one, outk_valid stays 1. This gives full throughput of 1 word/cycle per channel.
- The channel not selected is unaffected by the transfer; its drain proceeds independently.
- Transfer with sel = 2/3:
  - Word discarded; no output channel changes.
  - drop_err = 1 for exactly the next cycle (registered).
  - drop_cnt increments, holding at 2^CNT_W - 1.
- Back-to-back invalid transfers: drop_err stays high for each such cycle; drop_cnt increments every cycle.
- Stall rules:
  - A valid output word holds outk_data stable until accepted.
  - outk_valid never deasserts without outk_ready.
- Source must hold in_data/in_sel stable while in_valid & !in_ready. The block does not check this.
- No reordering within a channel. Words are delivered in acceptance order.
- No combinational path from in_valid/in_data to any output other than none; in_ready depends only on in_sel and out*_valid/out*_ready.

Test Plan:
- Reset mid-operation: load ch0 with 0x12345678 (out0_ready = 0), assert rst_n = 0 between clock edges -> out0_valid drops to 0 immediately, drop_cnt = 0; after release the first accepted word appears correctly.
- Streaming: sel = 0, words 0x00000001..0x00000008 on consecutive cycles with out0_ready = 1 -> in_ready held 1, out0 shows each word 1 cycle later, 8 words in order, out1_valid stays 0.
- Backpressure: sel = 1, word 0xFFFFFFFF with out1_ready = 0 -> out1_valid = 1, in_ready = 0 for sel = 1 while in_ready = 1 for sel = 0. Raise out1_ready -> next word 0xA5A5A5A5 accepted on the same edge the old word drains.
- Independent channels: alternate sel 0/1 with out0_ready = 0, out1_ready = 1 -> ch1 words stream through; ch0 holds its first word and blocks only sel = 0.
- Invalid select: sel = 2 with 0xDEADBEEF, then sel = 3 with 0xCAFEF00D -> drop_err high two cycles, drop_cnt = 2, neither out valid asserts.
- Saturation: 300 consecutive sel = 3 transfers -> drop_cnt = 255 and holds; drop_err high for 300 cycles.
